// File: rtl/rng_pkg.sv
// rng_pkg: state encoding and synchroniser depth shared by the RNG sample controller
package rng_pkg;
    typedef enum logic [1:0] {IDLE, WARMUP, SAMPLE, HOLD} rng_state_t;
    localparam int RNG_SYNC_STAGES = 2;
endpackage

// File: rtl/rng_word_fifo.sv
// rng_word_fifo: synchronous word FIFO with registered head, level and simultaneous push/pop
module rng_word_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [AW:0]   level_o
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] level_q;
    logic do_push, do_pop;
    assign do_pop = pop_i && level_q != '0;
    assign do_push = push_i && (level_q != FULL || do_pop);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    assign head_o = mem_q[rd_q];
    assign level_o = level_q;
endmodule

// File: rtl/rng_sample_controller.sv
// rng_sample_controller: gates/settles/samples the RO array, folds samples into words, buffers them in a FIFO.
// Define RNG_HEALTH_TEST_EN to drop all-zero, all-one and repeated words and raise sticky health_fail.
module rng_sample_controller
    import rng_pkg::*;
#(
    parameter int NUMBITS = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_DIV = 4,
    parameter int WORD_SAMPLES = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [NUMBITS-1:0] ro_bits,
    output logic               ro_enable,
    output logic [NUMBITS-1:0] rnd_data,
    output logic               rnd_valid,
    input  logic               rnd_ready,
    output logic [LW-1:0]      fifo_level,
    output logic               health_fail
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int NW = $clog2(WORD_SAMPLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LOAD = DW'(SAMPLE_DIV - 1);
    localparam logic [NW-1:0] LAST_SAMPLE = NW'(WORD_SAMPLES - 1);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] ALMOST = LW'(FIFO_DEPTH - 1);
    rng_state_t state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [DW-1:0] div_q, div_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [NUMBITS-1:0] acc_q, acc_d, word_q, word_d, folded, sync_bits;
    logic [NUMBITS-1:0] sync_q [RNG_SYNC_STAGES];
    logic push_q, push_d, pop, hold_req, word_done, word_end, word_ok;
    assign sync_bits = sync_q[RNG_SYNC_STAGES-1];
    assign folded = {acc_q[NUMBITS-2:0], acc_q[NUMBITS-1]} ^ sync_bits;
    assign word_done = cnt_q == LAST_SAMPLE;
    assign word_end = run && state_q == SAMPLE && div_q == '0 && word_done;
    assign ro_enable = state_q == WARMUP || state_q == SAMPLE;
    assign rnd_valid = fifo_level != '0;
    assign pop = rnd_valid && rnd_ready;
    // The push that fills the last free slot stops the oscillators until space returns
    assign hold_req = push_q && fifo_level == ALMOST && !pop;
    always_comb begin
        state_d = state_q;
        settle_d = settle_q;
        div_d = div_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        push_d = word_end && word_ok;
        word_d = word_end ? folded : word_q;
        case (state_q)
            IDLE: begin
                state_d = WARMUP;
                settle_d = SETTLE_LOAD;
            end
            WARMUP: begin
                state_d = settle_q == '0 ? SAMPLE : WARMUP;
                settle_d = settle_q - 1'b1;
                div_d = DIV_LOAD;
                cnt_d = '0;
                acc_d = '0;
            end
            SAMPLE: begin
                div_d = div_q == '0 ? DIV_LOAD : div_q - 1'b1;
                cnt_d = div_q != '0 ? cnt_q : word_done ? '0 : cnt_q + 1'b1;
                acc_d = div_q != '0 ? acc_q : word_done ? '0 : folded;
                state_d = hold_req ? HOLD : SAMPLE;
            end
            HOLD: begin
                state_d = fifo_level != FULL ? WARMUP : HOLD;
                settle_d = SETTLE_LOAD;
            end
            default: state_d = IDLE;
        endcase
        if (!run) state_d = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            settle_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            word_q <= '0;
            push_q <= 1'b0;
            for (int i = 0; i < RNG_SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            state_q <= state_d;
            settle_q <= settle_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            word_q <= word_d;
            push_q <= push_d;
            sync_q[0] <= ro_bits;
            for (int i = 1; i < RNG_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
`ifdef RNG_HEALTH_TEST_EN
    logic [NUMBITS-1:0] last_q, last_d;
    logic fail_q, fail_d;
    assign word_ok = folded != '0 && folded != '1 && folded != last_q;
    always_comb begin
        last_d = word_end && word_ok ? folded : last_q;
        fail_d = fail_q || (word_end && !word_ok);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
            fail_q <= 1'b0;
        end else begin
            last_q <= last_d;
            fail_q <= fail_d;
        end
    end
    assign health_fail = fail_q;
`else
    assign word_ok = 1'b1;
    assign health_fail = 1'b0;
`endif
    rng_word_fifo #(.W(NUMBITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push_i(push_q),
        .data_i(word_q),
        .pop_i(rnd_ready),
        .head_o(rnd_data),
        .level_o(fifo_level)
    );
endmodule
